// File: rtl/gol_ctrl.sv
// Game of Life generation sequencer: owns the grid register, loads it row by row,
// and commits the rule datapath's next generation on RUN/STEP. Optional macro: GOL_CTRL_AUTOHALT_EN.
module gol_ctrl #(
   parameter int M        = 16,
   parameter int N        = 16,
   parameter int PERIOD_W = 16,
   parameter int GEN_W    = 16
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [2:0]          cmd_op_i,
   input  logic [PERIOD_W-1:0] period_i,
   input  logic                row_valid_i,
   output logic                row_ready_o,
   input  logic [M-1:0]        row_data_i,
   input  logic [N*M-1:0]      next_grid_i,
   output logic [N*M-1:0]      grid_o,
   output logic [GEN_W-1:0]    gen_o,
   output logic                gen_pulse_o,
   output logic                stable_o,
   output logic                empty_o,
   output logic [2:0]          state_o
);

   localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

   localparam logic [2:0] OP_RUN   = 3'd0;
   localparam logic [2:0] OP_PAUSE = 3'd1;
   localparam logic [2:0] OP_STEP  = 3'd2;
   localparam logic [2:0] OP_CLEAR = 3'd3;
   localparam logic [2:0] OP_LOAD  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_HALT = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [N*M-1:0]      grid_q, grid_d;
   logic [GEN_W-1:0]    gen_q, gen_d;
   logic                stable_q, stable_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] timer_q, timer_d;
   logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;

   logic                cmd_fire;
   logic                row_fire;
   logic                timer_hit;
   logic                commit;
   logic [PERIOD_W-1:0] period_eff;
   logic [N-1:0]        row_we;

   assign cmd_ready_o = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALT);
   assign row_ready_o = (state_q == ST_LOAD);
   assign cmd_fire    = cmd_valid_i && cmd_ready_o;
   assign row_fire    = row_valid_i && row_ready_o;
   assign timer_hit   = (timer_q == period_q - PERIOD_W'(1));
   assign period_eff  = (period_i == '0) ? PERIOD_W'(1) : period_i;

   // One write enable per grid row, selected by the load row counter.
   for (genvar gi = 0; gi < N; gi++) begin : g_row_we
      assign row_we[gi] = row_fire && (row_cnt_q == ROW_W'(gi));
   end

   always_comb begin
      state_d   = state_q;
      grid_d    = grid_q;
      gen_d     = gen_q;
      stable_d  = stable_q;
      period_d  = period_q;
      timer_d   = timer_q;
      row_cnt_d = row_cnt_q;
      commit    = 1'b0;

      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (cmd_fire) begin
               case (cmd_op_i)
                  OP_RUN: begin
                     state_d  = ST_RUN;
                     period_d = period_eff;
                     timer_d  = '0;
                  end
                  OP_STEP: state_d = ST_STEP;
                  OP_LOAD: begin
                     state_d   = ST_LOAD;
                     row_cnt_d = '0;
                     gen_d     = '0;
                  end
                  OP_CLEAR: begin
                     state_d  = ST_IDLE;
                     grid_d   = '0;
                     gen_d    = '0;
                     stable_d = 1'b0;
                  end
                  OP_PAUSE: state_d = ST_IDLE;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            // PAUSE and CLEAR pre-empt a due commit; RUN commits and restarts the period.
            if (cmd_fire && cmd_op_i == OP_PAUSE) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else if (cmd_fire && cmd_op_i == OP_CLEAR) begin
               state_d  = ST_IDLE;
               grid_d   = '0;
               gen_d    = '0;
               stable_d = 1'b0;
               timer_d  = '0;
            end else if (cmd_fire && cmd_op_i == OP_RUN) begin
               period_d = period_eff;
               timer_d  = '0;
               commit   = timer_hit;
            end else if (timer_hit) begin
               commit  = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + PERIOD_W'(1);
            end
         end
         ST_STEP: begin
            commit  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_LOAD: begin
            for (int r = 0; r < N; r++) begin
               if (row_we[r]) begin
                  grid_d[r*M +: M] = row_data_i;
               end
            end
            if (row_fire) begin
               if (row_cnt_q == LAST_ROW) begin
                  state_d  = ST_IDLE;
                  stable_d = 1'b0;
               end else begin
                  row_cnt_d = row_cnt_q + ROW_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (commit) begin
         grid_d   = next_grid_i;
         gen_d    = gen_q + GEN_W'(1);
         stable_d = (next_grid_i == grid_q);
`ifdef GOL_CTRL_AUTOHALT_EN
         if (state_q == ST_RUN && (next_grid_i == grid_q || next_grid_i == '0)) begin
            state_d = ST_HALT;
         end
`endif
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_IDLE;
         grid_q    <= '0;
         gen_q     <= '0;
         stable_q  <= 1'b0;
         period_q  <= PERIOD_W'(1);
         timer_q   <= '0;
         row_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grid_q    <= grid_d;
         gen_q     <= gen_d;
         stable_q  <= stable_d;
         period_q  <= period_d;
         timer_q   <= timer_d;
         row_cnt_q <= row_cnt_d;
      end
   end

   assign grid_o      = grid_q;
   assign gen_o       = gen_q;
   assign gen_pulse_o = commit;
   assign stable_o    = stable_q;
   assign empty_o     = (grid_q == '0);
   assign state_o     = state_q;

endmodule
